// File: rtl/fifo_pkg.sv
// Shared constants, read-mode enum and elaboration helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int FIFO_DEPTH      = 8;
  localparam int FIFO_DATA_WIDTH = 16;

  typedef enum logic {
    RD_FWFT       = 1'b0,
    RD_REGISTERED = 1'b1
  } fifo_rd_mode_e;

  function automatic fifo_rd_mode_e rd_mode_from_fwft(input int fwft);
    return (fwft != 0) ? RD_FWFT : RD_REGISTERED;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one combinational read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately left unreset; validity is tracked by the pointers.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with occupancy count, programmable almost thresholds,
// flush, sticky overflow/underflow and selectable FWFT or registered read.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam fifo_rd_mode_e RD_MODE = rd_mode_from_fwft(FWFT);

  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_CNT    = PW'(AE_THRESH);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "fifo_param: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "fifo_param: DATA_WIDTH must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_param: AF_THRESH=%0d out of range 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_param: AE_THRESH=%0d out of range 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come from the count register only, so a request never gates itself.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign mem_we = wr_acc && rst_n && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_ptr     <= '0;
      w_ptr     <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (r_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  if (RD_MODE == RD_FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = !empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Flush drops rd_valid but keeps the last word visible on rd_data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    count_q == PW'(w_ptr - r_ptr));

  a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_CNT);

  a_full_empty_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));

  a_blocked_wr_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (!flush && !wr_acc) |=> $stable(w_ptr));

  a_blocked_rd_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (!flush && !rd_acc) |=> $stable(r_ptr));

  a_clear_gives_empty : assert property (@(posedge clk)
    (!rst_n || flush) |=> empty);

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param: FWFT depth 8, FWFT depth 4, registered depth 8.
module tb_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  // u_a: DEPTH=8, FWFT=1
  logic        a_flush = 0, a_wr_en = 0, a_rd_en = 0;
  logic [15:0] a_wr_data = '0, a_rd_data;
  logic        a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0]  a_count;

  // u_b: DEPTH=4, FWFT=1
  logic        b_flush = 0, b_wr_en = 0, b_rd_en = 0;
  logic [15:0] b_wr_data = '0, b_rd_data;
  logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0]  b_count;

  // u_c: DEPTH=8, FWFT=0
  logic        c_flush = 0, c_wr_en = 0, c_rd_en = 0;
  logic [15:0] c_wr_data = '0, c_rd_data;
  logic        c_rd_valid, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0]  c_count;

  fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
    .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  fifo_param #(.DATA_WIDTH(16), .DEPTH(4), .FWFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
    .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr_en), .wr_data(c_wr_data),
    .rd_en(c_rd_en), .rd_data(c_rd_data), .rd_valid(c_rd_valid), .full(c_full),
    .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (a_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", a_count); else passed++;
    total++; if ({a_empty, a_full, a_ae, a_af} !== 4'b1010)
      $display("FAIL reset_flags got=%b exp=1010", {a_empty, a_full, a_ae, a_af}); else passed++;
    total++; if ({a_ovf, a_unf, a_rd_valid} !== 3'b000)
      $display("FAIL reset_err_valid got=%b exp=000", {a_ovf, a_unf, a_rd_valid}); else passed++;
    total++; if ({c_rd_valid, c_rd_data} !== 17'h0_0000)
      $display("FAIL reset_reg_rd got_valid=%b got_data=%h exp=0/0000", c_rd_valid, c_rd_data); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      a_wr_en = 1'b1;
      a_wr_data = 16'(i);
      tick();
      total++; if (a_count !== 4'(i)) $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a_count, i); else passed++;
      total++; if (a_af !== (i >= 6)) $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, a_af, (i >= 6)); else passed++;
      total++; if (a_full !== (i == 8)) $display("FAIL fill_full[%0d] got=%b exp=%b", i, a_full, (i == 8)); else passed++;
    end
    a_wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      total++; if (a_rd_data !== 16'(i) || a_rd_valid !== 1'b1)
        $display("FAIL drain_data[%0d] got=%h/%b exp=%h/1", i, a_rd_data, a_rd_valid, 16'(i)); else passed++;
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      total++; if (a_ae !== ((8 - i) <= 1))
        $display("FAIL drain_almost_empty[%0d] got=%b exp=%b", i, a_ae, ((8 - i) <= 1)); else passed++;
    end
    total++; if ({a_empty, a_count} !== {1'b1, 4'd0})
      $display("FAIL drain_empty got=%b/%0d exp=1/0", a_empty, a_count); else passed++;
    total++; if ({a_ovf, a_unf} !== 2'b00) $display("FAIL drain_errors got=%b exp=00", {a_ovf, a_unf}); else passed++;
  endtask

  task automatic test_full_empty_collision();
    for (int i = 0; i < 4; i++) begin
      b_wr_en = 1'b1;
      b_wr_data = 16'h0010 + 16'(i);
      tick();
    end
    total++; if ({b_full, b_af, b_count} !== {1'b1, 1'b1, 3'd4})
      $display("FAIL coll_full got=%b%b/%0d exp=11/4", b_full, b_af, b_count); else passed++;
    b_wr_data = 16'h00FF;
    b_rd_en = 1'b1;
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 1'b0;
    total++; if ({b_count, b_full} !== {3'd3, 1'b0})
      $display("FAIL coll_full_rw got=%0d/%b exp=3/0", b_count, b_full); else passed++;
    total++; if (b_ovf !== 1'b1) $display("FAIL coll_overflow got=%b exp=1", b_ovf); else passed++;
    tick();
    total++; if (b_ovf !== 1'b1) $display("FAIL coll_overflow_sticky got=%b exp=1", b_ovf); else passed++;
    for (int i = 1; i < 4; i++) begin
      total++; if (b_rd_data !== 16'h0010 + 16'(i))
        $display("FAIL coll_drain[%0d] got=%h exp=%h", i, b_rd_data, 16'h0010 + 16'(i)); else passed++;
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
    end
    total++; if ({b_empty, b_unf} !== 2'b10) $display("FAIL coll_empty got=%b exp=10", {b_empty, b_unf}); else passed++;
    b_wr_en = 1'b1;
    b_rd_en = 1'b1;
    b_wr_data = 16'h0055;
    tick();
    b_wr_en = 1'b0;
    b_rd_en = 1'b0;
    total++; if ({b_count, b_unf, b_ovf} !== {3'd1, 1'b1, 1'b1})
      $display("FAIL coll_empty_rw got=%0d/%b/%b exp=1/1/1", b_count, b_unf, b_ovf); else passed++;
    total++; if (b_rd_data !== 16'h0055) $display("FAIL coll_empty_data got=%h exp=0055", b_rd_data); else passed++;
  endtask

  task automatic test_registered_read();
    c_wr_en = 1'b1;
    c_wr_data = 16'hBEEF;
    tick();
    c_wr_data = 16'hCAFE;
    tick();
    c_wr_en = 1'b0;
    total++; if ({c_count, c_rd_valid} !== {4'd2, 1'b0})
      $display("FAIL reg_prefill got=%0d/%b exp=2/0", c_count, c_rd_valid); else passed++;
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    total++; if ({c_rd_valid, c_rd_data} !== {1'b1, 16'hBEEF})
      $display("FAIL reg_first got=%b/%h exp=1/beef", c_rd_valid, c_rd_data); else passed++;
    tick();
    total++; if ({c_rd_valid, c_rd_data} !== {1'b0, 16'hBEEF})
      $display("FAIL reg_hold got=%b/%h exp=0/beef", c_rd_valid, c_rd_data); else passed++;
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    total++; if ({c_rd_valid, c_rd_data, c_count} !== {1'b1, 16'hCAFE, 4'd0})
      $display("FAIL reg_second got=%b/%h/%0d exp=1/cafe/0", c_rd_valid, c_rd_data, c_count); else passed++;
    tick();
  endtask

  task automatic test_wrap_around();
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    total++; if ({b_count, b_ovf, b_unf} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL wrap_flush got=%0d/%b/%b exp=0/0/0", b_count, b_ovf, b_unf); else passed++;
    for (int k = 0; k < 20; k++) begin
      b_wr_en = 1'b1;
      b_wr_data = 16'h0100 + 16'(k);
      tick();
      b_wr_en = 1'b0;
      total++; if ({b_count, b_rd_data} !== {3'd1, 16'h0100 + 16'(k)})
        $display("FAIL wrap_write[%0d] got=%0d/%h exp=1/%h", k, b_count, b_rd_data, 16'h0100 + 16'(k)); else passed++;
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      total++; if (b_count !== 3'd0) $display("FAIL wrap_read[%0d] got=%0d exp=0", k, b_count); else passed++;
    end
  endtask

  task automatic test_flush_and_reset();
    c_rd_en = 1'b1;
    tick();
    c_rd_en = 1'b0;
    total++; if ({c_unf, c_rd_valid} !== 2'b10) $display("FAIL fl_underflow got=%b exp=10", {c_unf, c_rd_valid}); else passed++;
    for (int i = 0; i < 5; i++) begin
      c_wr_en = 1'b1;
      c_wr_data = 16'h00A0 + 16'(i);
      tick();
    end
    c_wr_en = 1'b0;
    total++; if (c_count !== 4'd5) $display("FAIL fl_prefill got=%0d exp=5", c_count); else passed++;
    c_flush = 1'b1;
    c_wr_en = 1'b1;
    c_rd_en = 1'b1;
    c_wr_data = 16'h00EE;
    tick();
    c_flush = 1'b0;
    c_wr_en = 1'b0;
    c_rd_en = 1'b0;
    total++; if ({c_count, c_empty, c_ovf, c_unf, c_rd_valid} !== {4'd0, 1'b1, 3'b000})
      $display("FAIL fl_clear got=%0d/%b/%b/%b/%b exp=0/1/0/0/0", c_count, c_empty, c_ovf, c_unf, c_rd_valid); else passed++;
    tick();
    total++; if ({c_count, c_rd_data} !== {4'd0, 16'hCAFE})
      $display("FAIL fl_no_accept got=%0d/%h exp=0/cafe", c_count, c_rd_data); else passed++;
    for (int i = 1; i <= 3; i++) begin
      c_wr_en = 1'b1;
      c_wr_data = 16'h0011 * 16'(i);
      tick();
    end
    c_wr_en = 1'b0;
    c_rd_en = 1'b1;
    tick();
    total++; if ({c_rd_valid, c_rd_data, c_count} !== {1'b1, 16'h0011, 4'd2})
      $display("FAIL rst_pre got=%b/%h/%0d exp=1/0011/2", c_rd_valid, c_rd_data, c_count); else passed++;
    rst_n = 1'b0;
    c_wr_en = 1'b1;
    c_wr_data = 16'h0044;
    tick();
    total++; if ({c_count, c_empty, c_full, c_ae, c_af} !== {4'd0, 4'b1010})
      $display("FAIL rst_mid_flags got=%0d/%b%b%b%b exp=0/1010", c_count, c_empty, c_full, c_ae, c_af); else passed++;
    total++; if ({c_rd_valid, c_rd_data, c_ovf, c_unf} !== {1'b0, 16'h0000, 2'b00})
      $display("FAIL rst_mid_rd got=%b/%h/%b%b exp=0/0000/00", c_rd_valid, c_rd_data, c_ovf, c_unf); else passed++;
    rst_n = 1'b1;
    c_wr_en = 1'b0;
    c_rd_en = 1'b0;
    tick();
    total++; if ({c_count, c_rd_valid} !== {4'd0, 1'b0})
      $display("FAIL rst_release got=%0d/%b exp=0/0", c_count, c_rd_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_empty_collision();
    test_registered_read();
    test_wrap_around();
    test_flush_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation synchronous FIFO for the microISA-16 datapath, used between fetch/decode and other producer/consumer stages.
- Fully parametrised in width, depth and read mode.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, synchronous flush, and sticky overflow/underflow error flags.
- Single clock domain.

Parameters:
- DATA_WIDTH, 16, width of each entry in bits (>=1).
- DEPTH, 8, number of entries; must be a power of 2 and >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 1, read mode: 1 = first-word-fall-through (combinational rd_data); 0 = registered read with 1-cycle latency.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data is valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- **Pointers:** r and w are $clog2(DEPTH)+1 bits wide (one extra wrap bit). The index is the low bits. Pointers wrap naturally modulo 2*DEPTH.
- **count register:** +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
- **Status flags:** full, empty, almost_full and almost_empty decode combinationally from the count register only, never from wr_en/rd_en.
- **Write acceptance:** accepted = wr_en && !full. Full blocks the write even if a read is accepted in the same cycle.
- **Read acceptance:** accepted = rd_en && !empty. Empty blocks the read even if a write is accepted in the same cycle (no bypass).
- **Full with simultaneous read and write:** only the read is accepted; count becomes DEPTH-1.
- **Empty with simultaneous read and write:** only the write is accepted; count becomes 1.
- **Error flags:**
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - Both hold until rst_n low or flush.
  - Blocked requests never move pointers or memory.
- **FWFT=1:** rd_data = mem[r_idx] combinationally; rd_valid = !empty. An accepted read advances r at the edge.
- **FWFT=0:**
  - An accepted read registers mem[r_idx] into rd_data and sets rd_valid=1 in the next cycle.
  - rd_valid=0 in any cycle following a non-accepted read.
  - rd_data holds its last value when not updated.
- **Reset (rst_n=0 at edge):** r=w=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), overflow=underflow=0, rd_valid=0, registered rd_data=0.
  - Memory contents are not reset.
  - Reset overrides all other inputs, including mid-operation.
- **flush=1 at edge:** same effect as reset except memory and registered rd_data. Flush takes priority over wr_en/rd_en in the same cycle; no write or read is accepted.
- **Elaboration checks:** $fatal on DEPTH not a power of 2, DEPTH<2, DATA_WIDTH==0, or thresholds out of range.
- **Assertions:**
  - count == w-r.
  - count <= DEPTH.
  - full and empty are never both high.
  - Blocked requests leave pointers stable.
  - Flush/reset yield empty on the next cycle.

Decomposition:
- fifo_pkg gets default constants (FIFO_DEPTH, DATA_WIDTH) and a fifo_rd_mode_e enum (RD_FWFT, RD_REGISTERED); the FWFT parameter maps onto this enum.
- Sub-module fifo_mem holds the storage array:
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port (raddr, rdata).
- fifo_param holds the pointers, count, flags, error logic and read-mode output stage.

Test Plan:
1. DEPTH=8, FWFT=1: reset, write 0x0001..0x0008 -> count=8, full=1, almost_full from count=6; then 8 reads return 0x0001..0x0008 in order, empty=1, overflow=0, underflow=0.
2. DEPTH=4, full: wr_en=1, rd_en=1 same cycle -> only the read is accepted, count 4->3, overflow=1 and sticky; then with empty: rd_en=1, wr_en=1 -> only the write is accepted, count=1, underflow=1.
3. FWFT=0: write 0xBEEF, then 0xCAFE, then rd_en one cycle -> the next cycle shows rd_valid=1, rd_data=0xBEEF; the following cycle (rd_en=0) shows rd_valid=0, rd_data still 0xBEEF.
4. Wrap-around, DEPTH=4: run 20 interleaved write/read pairs with incrementing data -> data order is preserved across pointer wrap, and count stays in 0..1.
5. Flush with count=5 (DEPTH=8) and wr_en=rd_en=1 in the same cycle -> next cycle count=0, empty=1, overflow/underflow=0, no data accepted; rst_n=0 mid-burst gives the same result plus rd_valid=0.
